team_06_ctrl_fsm: RTL

TEAM_06_CTRL_FSM -- requirements
Module: team_06_ctrl_fsm

---
 rtl/team_06_ctrl_fsm_if.sv | 39 +++
 rtl/team_06_ctrl_fsm.sv | 133 +++++++++++++
 2 files changed

// File: rtl/team_06_ctrl_fsm_if.sv
// Audio intercom controller bus.
// Carries the live audio samples, the push-to-talk level, the raw buttons
// and every status output of team_06_ctrl_fsm. The clock and reset are
// plain ports on the module and are not part of this bus.
//   master : drives mic_aud, spk_aud, ptt_en, ng_btn, effect_btn, mute_btn
//   slave  : drives state, vol_en, effect_en, current_effect, mute_tog,
//            ng_on, hang_cnt
interface team_06_ctrl_fsm_if #(
  parameter int WIDTH       = 8,
  parameter int NUM_EFFECTS = 5,
  parameter int HANG_CYCLES = 1024
);
  localparam int EW = $clog2(NUM_EFFECTS);
  localparam int HW = $clog2(HANG_CYCLES + 1);

  logic [WIDTH-1:0] mic_aud;
  logic [WIDTH-1:0] spk_aud;
  logic             ptt_en;
  logic             ng_btn;
  logic             effect_btn;
  logic             mute_btn;
  logic [1:0]       state;
  logic             vol_en;
  logic             effect_en;
  logic [EW-1:0]    current_effect;
  logic             mute_tog;
  logic             ng_on;
  logic [HW-1:0]    hang_cnt;

  modport master (
    output mic_aud, spk_aud, ptt_en, ng_btn, effect_btn, mute_btn,
    input  state, vol_en, effect_en, current_effect, mute_tog, ng_on, hang_cnt
  );

  modport slave (
    input  mic_aud, spk_aud, ptt_en, ng_btn, effect_btn, mute_btn,
    output state, vol_en, effect_en, current_effect, mute_tog, ng_on, hang_cnt
  );
endinterface

// File: rtl/team_06_ctrl_fsm.sv
// Intercom talk/listen controller with noise gate and effect selector.
// Ports:
//   clk  : single rising-edge clock
//   nrst : asynchronous active-low reset
//   bus  : team_06_ctrl_fsm_if slave (audio, ptt, buttons in; status out)
//
// state | meaning
// LIST  | listening: speaker path enabled unless muted
// TALK  | talking: effect path enabled, held by ptt or an open gate
// HANG  | gate hang time: talk held while hang_cnt runs down
module team_06_ctrl_fsm #(
  parameter int WIDTH       = 8,
  parameter int THRESH      = 64,
  parameter int NUM_EFFECTS = 5,
  parameter int DEB_CYCLES  = 16,
  parameter int HANG_CYCLES = 1024
) (
  input logic              clk,
  input logic              nrst,
  team_06_ctrl_fsm_if.slave bus
);
  localparam int EW = $clog2(NUM_EFFECTS);
  localparam int HW = $clog2(HANG_CYCLES + 1);
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam logic [WIDTH-1:0] MID = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH:0]   TH  = (WIDTH+1)'(THRESH);

  typedef enum logic [1:0] {LIST = 2'd0, TALK = 2'd1, HANG = 2'd2} state_t;

  // bit 0 ng, bit 1 effect, bit 2 mute, bit 3 ptt
  logic [3:0] sync1_q, sync2_q;
  logic [2:0] lvl_q, lvl_d, press;
  logic [2:0][DW-1:0] cnt_q, cnt_d;

  logic [EW-1:0] eff_q, eff_d;
  logic          mute_q, ng_q;
  state_t        state_q, state_d;
  logic [HW-1:0] hang_q, hang_d;

  logic [WIDTH-1:0] dev;
  logic             check, spk_active, ptt, open_req;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      lvl_q   <= '0;
      cnt_q   <= '0;
      eff_q   <= '0;
      mute_q  <= 1'b0;
      ng_q    <= 1'b0;
      state_q <= LIST;
      hang_q  <= '0;
    end else begin
      sync1_q <= {bus.ptt_en, bus.mute_btn, bus.effect_btn, bus.ng_btn};
      sync2_q <= sync1_q;
      lvl_q   <= lvl_d;
      cnt_q   <= cnt_d;
      eff_q   <= eff_d;
      mute_q  <= mute_q ^ press[2];
      ng_q    <= ng_q ^ press[0];
      state_q <= state_d;
      hang_q  <= hang_d;
    end
  end

  // The press pulse fires in the cycle the debounced level is about to
  // rise, so the toggles land on the same edge as the new level.
  always_comb begin
    lvl_d = lvl_q;
    cnt_d = '0;
    press = '0;
    for (int i = 0; i < 3; i++) begin
      if (sync2_q[i] != lvl_q[i]) begin
        if (cnt_q[i] == DW'(DEB_CYCLES - 1)) begin
          lvl_d[i] = sync2_q[i];
          press[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    eff_d = eff_q;
    if (press[1]) begin
      eff_d = (eff_q >= EW'(NUM_EFFECTS - 1)) ? '0 : eff_q + 1'b1;
    end
  end

  assign dev        = (bus.mic_aud >= MID) ? (bus.mic_aud - MID) : (MID - bus.mic_aud);
  assign check      = ({1'b0, dev} >= TH);
  assign spk_active = (bus.spk_aud != MID);
  assign ptt        = sync2_q[3];
  assign open_req   = ptt || (ng_q && check);

  always_comb begin
    state_d = state_q;
    hang_d  = '0;
    case (state_q)
      LIST: begin
        if (!spk_active && open_req) state_d = TALK;
      end
      TALK: begin
        if (spk_active)            state_d = LIST;
        else if (!ptt && !ng_q)    state_d = LIST;
        else if (!ptt && !check) begin
          state_d = HANG;
          hang_d  = HW'(HANG_CYCLES);
        end
      end
      HANG: begin
        if (spk_active)            state_d = LIST;
        else if (open_req)         state_d = TALK;
        else if (!ng_q)            state_d = LIST;
        else if (hang_q == HW'(1)) state_d = LIST;
        else begin
          hang_d = hang_q - 1'b1;
        end
      end
      default: state_d = LIST;
    endcase
  end

  assign bus.state          = state_q;
  assign bus.vol_en         = (state_q == LIST) && !mute_q;
  assign bus.effect_en      = (state_q == TALK) || (state_q == HANG);
  assign bus.current_effect = eff_q;
  assign bus.mute_tog       = mute_q;
  assign bus.ng_on          = ng_q;
  assign bus.hang_cnt       = hang_q;
endmodule
